// File: rtl/sync_fifo_pkg.sv
// Shared types and default configuration for the flagged synchronous FIFO.
// Read-mode selection plus configuration sanity helper.
package sync_fifo_pkg;

   typedef enum logic {
      STANDARD = 1'b0,
      FWFT     = 1'b1
   } read_mode_e;

   localparam int DEF_DATA_WIDTH         = 32;
   localparam int DEF_FIFO_DEPTH         = 16;
   localparam int DEF_ALMOST_FULL_LEVEL  = 14;
   localparam int DEF_ALMOST_EMPTY_LEVEL = 2;

   // Depth must be a power of two >= 4; thresholds strictly ordered.
   function automatic logic levels_ok(
      input int depth,
      input int af_level,
      input int ae_level
   );
      logic pow2;
      pow2 = (depth > 0) && ((depth & (depth - 1)) == 0);
      return pow2 && (depth >= 4) && (ae_level >= 0) &&
             (ae_level < af_level) && (af_level <= depth);
   endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Read and write ports share one clock.
module dual_port_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with registered full/empty/almost flags, error pulses
// and a selectable registered or first-word-fall-through read port.
module sync_fifo_flags
   import sync_fifo_pkg::*;
#(
   parameter int         DATA_WIDTH         = DEF_DATA_WIDTH,
   parameter int         FIFO_DEPTH         = DEF_FIFO_DEPTH,
   parameter int         ALMOST_FULL_LEVEL  = DEF_ALMOST_FULL_LEVEL,
   parameter int         ALMOST_EMPTY_LEVEL = DEF_ALMOST_EMPTY_LEVEL,
   parameter read_mode_e READ_MODE          = STANDARD,
   localparam int        ADDR_WIDTH         = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  fifo_almost_full,
   output logic                  fifo_almost_empty,
   output logic [ADDR_WIDTH:0]   fill_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] AF_C    = PTR_W'(ALMOST_FULL_LEVEL);
   localparam logic [PTR_W-1:0] AE_C    = PTR_W'(ALMOST_EMPTY_LEVEL);

   if (!levels_ok(FIFO_DEPTH, ALMOST_FULL_LEVEL,
                  ALMOST_EMPTY_LEVEL)) begin : g_bad_cfg
      $error("sync_fifo_flags: illegal depth/level configuration");
   end

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr_next;
   logic [PTR_W-1:0]      rd_ptr_next;
   logic [PTR_W-1:0]      count_next;
   logic                  rd_accept;
   logic                  wr_accept;
   logic [DATA_WIDTH-1:0] ram_rd_data;
   logic [DATA_WIDTH-1:0] std_data;
   logic                  std_valid;

   // A full FIFO still takes a write when the same cycle frees a slot.
   always_comb begin
      rd_accept   = rd_en && !fifo_empty;
      wr_accept   = wr_en && (!fifo_full || rd_accept);
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      if (wr_accept) begin
         wr_ptr_next = wr_ptr + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_next = rd_ptr + 1'b1;
      end
      count_next = wr_ptr_next - rd_ptr_next;
   end

   dual_port_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
      .wr_data (data_in),
      .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
      .rd_data (ram_rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         fill_count        <= '0;
         fifo_full         <= 1'b0;
         fifo_empty        <= 1'b1;
         fifo_almost_full  <= 1'b0;
         fifo_almost_empty <= 1'b1;
         overflow          <= 1'b0;
         underflow         <= 1'b0;
      end else begin
         wr_ptr            <= wr_ptr_next;
         rd_ptr            <= rd_ptr_next;
         fill_count        <= count_next;
         fifo_full         <= (count_next == DEPTH_C);
         fifo_empty        <= (count_next == '0);
         fifo_almost_full  <= (count_next >= AF_C);
         fifo_almost_empty <= (count_next <= AE_C);
         overflow          <= wr_en && !wr_accept;
         underflow         <= rd_en && !rd_accept;
      end
   end

   // Registered read port: async RAM read is captured before the
   // same-edge write, so a full read+write returns the old word.
   always_ff @(posedge clk) begin
      if (reset) begin
         std_data  <= '0;
         std_valid <= 1'b0;
      end else begin
         std_valid <= rd_accept;
         if (rd_accept) begin
            std_data <= ram_rd_data;
         end
      end
   end

   always_comb begin
      data_out   = std_data;
      data_valid = std_valid;
      if (READ_MODE == FWFT) begin
         data_out   = fifo_empty ? '0 : ram_rd_data;
         data_valid = !fifo_empty;
      end
   end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: STANDARD and FWFT instances share one stimulus
// stream and are compared each cycle against a queue-based model.
module tb_sync_fifo_flags;
   import sync_fifo_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] data_in;
   logic          rd_en;

   logic [DW-1:0] s_data_out, f_data_out;
   logic          s_valid, f_valid;
   logic          s_full, f_full, s_empty, f_empty;
   logic          s_af, f_af, s_ae, f_ae;
   logic [4:0]    s_count, f_count;
   logic          s_ovf, f_ovf, s_udf, f_udf;

   sync_fifo_flags #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
      .ALMOST_FULL_LEVEL(AF), .ALMOST_EMPTY_LEVEL(AE),
      .READ_MODE(STANDARD)
   ) u_std (
      .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(s_data_out), .data_valid(s_valid),
      .fifo_full(s_full), .fifo_empty(s_empty),
      .fifo_almost_full(s_af), .fifo_almost_empty(s_ae),
      .fill_count(s_count), .overflow(s_ovf), .underflow(s_udf)
   );

   sync_fifo_flags #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
      .ALMOST_FULL_LEVEL(AF), .ALMOST_EMPTY_LEVEL(AE),
      .READ_MODE(FWFT)
   ) u_fw (
      .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(f_data_out), .data_valid(f_valid),
      .fifo_full(f_full), .fifo_empty(f_empty),
      .fifo_almost_full(f_af), .fifo_almost_empty(f_ae),
      .fill_count(f_count), .overflow(f_ovf), .underflow(f_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Model state
   logic [DW-1:0] q[$];
   logic          m_ovf = 1'b0;
   logic          m_udf = 1'b0;
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_out = '0;
   logic          check_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                    name, act, exp, $time);
   endtask

   task automatic step(input logic w, input logic [DW-1:0] d,
                       input logic r, input logic rs);
      logic rd_ok, wr_ok;
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      reset   = rs;
      @(posedge clk);
      if (rs) begin
         q.delete();
         m_ovf = 1'b0; m_udf = 1'b0;
         m_valid = 1'b0; m_out = '0;
      end else begin
         rd_ok = r && (q.size() > 0);
         wr_ok = w && ((q.size() < DEPTH) || rd_ok);
         m_ovf = w && !wr_ok;
         m_udf = r && !rd_ok;
         m_valid = rd_ok;
         if (rd_ok) m_out = q.pop_front();
         if (wr_ok) q.push_back(d);
      end
      #1;
   endtask

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (check_en) begin
         int n;
         n = q.size();
         chk("s_count", s_count, n);
         chk("f_count", f_count, n);
         chk("s_full", s_full, n == DEPTH);
         chk("f_full", f_full, n == DEPTH);
         chk("s_empty", s_empty, n == 0);
         chk("f_empty", f_empty, n == 0);
         chk("s_af", s_af, n >= AF);
         chk("f_af", f_af, n >= AF);
         chk("s_ae", s_ae, n <= AE);
         chk("f_ae", f_ae, n <= AE);
         chk("s_ovf", s_ovf, m_ovf);
         chk("f_ovf", f_ovf, m_ovf);
         chk("s_udf", s_udf, m_udf);
         chk("f_udf", f_udf, m_udf);
         chk("s_valid", s_valid, m_valid);
         chk("s_data", s_data_out, m_out);
         chk("f_valid", f_valid, n > 0);
         chk("f_data", f_data_out, (n > 0) ? q[0] : '0);
      end
   end

   initial begin
      wr_en = 0; rd_en = 0; data_in = '0; reset = 1;
      step(0, '0, 0, 1);
      check_en = 1'b1;
      chk("rst_count", s_count, 0);
      chk("rst_empty", s_empty, 1);
      chk("rst_ae", s_ae, 1);
      chk("rst_full", s_full, 0);
      chk("rst_valid", s_valid, 0);
      chk("rst_data", s_data_out, 0);

      // Fill with 0x0..0xF; almost_full first seen at count 14
      for (int i = 0; i < 16; i++) begin
         step(1, DW'(i), 0, 0);
         chk("fill_count", s_count, i + 1);
         chk("fill_af", s_af, (i + 1) >= 14);
      end
      chk("full_flag", s_full, 1);
      step(1, 32'hDEAD, 0, 0);
      chk("ovf_pulse", s_ovf, 1);
      chk("ovf_count", s_count, 16);
      step(0, '0, 0, 0);
      chk("ovf_clear", s_ovf, 0);

      // Drain in STANDARD order
      for (int i = 0; i < 16; i++) begin
         step(0, '0, 1, 0);
         chk("drain_data", s_data_out, i);
         chk("drain_valid", s_valid, 1);
      end
      chk("drain_empty", s_empty, 1);
      step(0, '0, 1, 0);
      chk("udf_pulse", s_udf, 1);
      chk("udf_valid", s_valid, 0);
      step(0, '0, 0, 0);
      chk("udf_clear", s_udf, 0);

      // Refill, then read+write at full across the address wrap
      for (int i = 0; i < 16; i++) step(1, DW'(32'h20 + i), 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, DW'(32'h40 + i), 1, 0);
         chk("rw_count", s_count, 16);
         chk("rw_ovf", s_ovf, 0);
         chk("rw_data", s_data_out, 32'h20 + i);
      end
      for (int i = 0; i < 16; i++) begin
         step(0, '0, 1, 0);
         chk("wrap_data", s_data_out,
             (i < 8) ? (32'h28 + i) : (32'h40 + i - 8));
      end

      // Read+write on empty: write wins, read rejected
      step(1, 32'hA5, 1, 0);
      chk("e_rw_count", s_count, 1);
      chk("e_rw_udf", s_udf, 1);
      chk("e_rw_fdata", f_data_out, 32'hA5);
      chk("e_rw_fvalid", f_valid, 1);
      step(0, '0, 1, 0);
      chk("e_rw_sdata", s_data_out, 32'hA5);

      // Reset mid-operation with a pending write
      for (int i = 0; i < 9; i++) step(1, DW'(32'h70 + i), 0, 0);
      chk("pre_rst_count", s_count, 9);
      step(1, 32'h77, 0, 1);
      chk("mid_rst_count", s_count, 0);
      chk("mid_rst_empty", s_empty, 1);
      chk("mid_rst_valid", s_valid, 0);
      chk("mid_rst_fvalid", f_valid, 0);
      step(1, 32'h55, 0, 0);
      chk("post_rst_fdata", f_data_out, 32'h55);
      step(0, '0, 1, 0);
      chk("post_rst_sdata", s_data_out, 32'h55);
      step(0, '0, 0, 0);

      check_en = 1'b0;
      @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
